// File: rtl/fp_pkg.sv
// Shared defaults, helpers and stage record layouts for the FP add/sub pipe.
package fp_pkg;

    localparam int DEF_EXP_W   = 8;
    localparam int DEF_MAN_W   = 23;
    // hidden bit + fraction + 2 guard bits
    localparam int DEF_GUARD_W = DEF_MAN_W + 3;

    function automatic int guard_w(input int man_w);
        return man_w + 3;
    endfunction

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Stage records at the default format; the pipe declares the same
    // layout sized by its own parameters.
    typedef struct packed {
        logic                   sign;
        logic                   effsub;
        logic [DEF_EXP_W-1:0]   exp;
        logic [DEF_GUARD_W-1:0] m_big;
        logic [DEF_GUARD_W-1:0] m_small;
        logic                   valid;
    } s1_t;

    typedef struct packed {
        logic                   sign;
        logic [DEF_EXP_W-1:0]   exp;
        logic [DEF_GUARD_W:0]   sum;
        logic                   valid;
    } s2_t;

endpackage

// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle for fp_addsub_pipe.
interface fp_addsub_pipe_if
    import fp_pkg::*;
#(
    parameter int W = 1 + DEF_EXP_W + DEF_MAN_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         ovf;
    logic         unf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, ovf, unf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, ovf, unf
    );
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; returns N for an all-zero input.
module fp_lzc #(
    parameter int N     = 26,
    parameter int OUT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     d,
    output logic [OUT_W-1:0] cnt
);
    // Scan upward so the highest set bit makes the final assignment
    always_comb begin
        cnt = OUT_W'(N);
        for (int unsigned i = 0; i < N; i++) begin
            if (d[i]) cnt = OUT_W'(N - 1 - i);
        end
    end
endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor: align, add, normalise.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic            clk,
    input  logic            rst,
    fp_addsub_pipe_if.slave bus
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int GW  = guard_w(MAN_W);
    localparam int LZW = $clog2(GW + 1);
    localparam int EW2 = EXP_W + 2;
    localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);

    // Same layout as fp_pkg::s1_t / s2_t, sized by this instance
    typedef struct packed {
        logic             sign;
        logic             effsub;
        logic [EXP_W-1:0] exp;
        logic [GW-1:0]    m_big;
        logic [GW-1:0]    m_small;
        logic             valid;
    } stage1_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [GW:0]      sum;
        logic             valid;
    } stage2_t;

    stage1_t s1_d, s1_q;
    stage2_t s2_d, s2_q;

    logic                   en;
    logic [W-1:0]           res_d, res_q;
    logic                   ovf_d, ovf_q, unf_d, unf_q, ov_q;

    logic                   sa, sb, a_big;
    logic [EXP_W-1:0]       ea, eb, e_big, e_small, dif;
    logic [MAN_W:0]         ma, mb, m_big, m_small;

    logic [LZW-1:0]         lz;
    logic [GW-1:0]          norm;
    logic signed [EW2-1:0]  exp_n;
    logic                   unused_bits;

    assign en           = !(ov_q && !bus.out_ready);
    assign bus.in_ready = en && !rst;

    // Stage 1: hidden bit, magnitude swap, align small mantissa
    always_comb begin
        sa      = bus.a[W-1];
        sb      = bus.b[W-1] ^ bus.sub;
        ea      = bus.a[W-2 -: EXP_W];
        eb      = bus.b[W-2 -: EXP_W];
        ma      = (ea == '0) ? '0 : {1'b1, bus.a[MAN_W-1:0]};
        mb      = (eb == '0) ? '0 : {1'b1, bus.b[MAN_W-1:0]};
        a_big   = {ea, ma} >= {eb, mb};
        e_big   = a_big ? ea : eb;
        e_small = a_big ? eb : ea;
        m_big   = a_big ? ma : mb;
        m_small = a_big ? mb : ma;
        dif     = e_big - e_small;

        s1_d        = '0;
        s1_d.valid  = bus.in_valid;
        s1_d.sign   = a_big ? sa : sb;
        s1_d.effsub = sa ^ sb;
        s1_d.exp    = e_big;
        s1_d.m_big  = {m_big, 2'b00};
        if (int'(dif) < GW) s1_d.m_small = {m_small, 2'b00} >> dif;
    end

    // Stage 2: add or subtract aligned mantissas, carry kept in the top bit
    always_comb begin
        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.sign  = s1_q.sign;
        s2_d.exp   = s1_q.exp;
        if (s1_q.effsub)
            s2_d.sum = {1'b0, s1_q.m_big} + (~{1'b0, s1_q.m_small} + (GW+1)'(1));
        else
            s2_d.sum = {1'b0, s1_q.m_big} + {1'b0, s1_q.m_small};
    end

    fp_lzc #(.N(GW), .OUT_W(LZW)) u_lzc (
        .d   (s2_q.sum[GW-1:0]),
        .cnt (lz)
    );

    // Stage 3: normalise, truncate, clamp exponent range
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (s2_q.sum[GW]) begin
            norm  = s2_q.sum[GW:1];
            exp_n = EW2'(s2_q.exp) + EW2'(1);
        end else begin
            norm  = s2_q.sum[GW-1:0] << lz;
            exp_n = EW2'(s2_q.exp) - EW2'(lz);
        end
        if (s2_q.sum == '0) begin
            res_d = '0;
        end else if (exp_n >= EXP_MAX) begin
            res_d = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
        end else if (exp_n[EW2-1] || exp_n == '0) begin
            res_d = {s2_q.sign, {(EXP_W+MAN_W){1'b0}}};
            unf_d = 1'b1;
        end else begin
            res_d = {s2_q.sign, exp_n[EXP_W-1:0], norm[GW-2:2]};
        end
    end

    assign unused_bits = ^{norm[GW-1], norm[1:0]};

    // Pipeline registers: all stages advance together under the global enable
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            ov_q  <= 1'b0;
        end else if (en) begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            res_q <= res_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            ov_q  <= s2_q.valid;
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.result    = res_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe at single and half-like formats.
module tb_fp_addsub_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fp_addsub_pipe_if #(.W(32)) sp_if ();
    fp_addsub_pipe_if #(.W(16)) hp_if ();

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut_sp (
        .clk (clk),
        .rst (rst),
        .bus (sp_if.slave)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_hp (
        .clk (clk),
        .rst (rst),
        .bus (hp_if.slave)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sp_q[$];
    exp_t hp_q[$];

    int errs   = 0;
    int checks = 0;

    logic        held_v;
    logic [31:0] held_res;
    logic        held_ovf, held_unf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check("stall_hold_result", sp_if.result, held_res);
                    check("stall_hold_flags", {sp_if.out_valid, sp_if.ovf, sp_if.unf},
                          {1'b1, held_ovf, held_unf});
                end
                if (sp_if.out_valid && sp_if.out_ready) begin
                    if (sp_q.size() == 0) begin
                        check("sp_unexpected_output", sp_q.size(), 1);
                    end else begin
                        e = sp_q.pop_front();
                        check("sp_result", sp_if.result, e.res);
                        check("sp_flags", {sp_if.ovf, sp_if.unf}, {e.ovf, e.unf});
                        if (e.lat) check("sp_latency", cyc - e.acc, 3);
                    end
                end
                held_v   = sp_if.out_valid && !sp_if.out_ready;
                held_res = sp_if.result;
                held_ovf = sp_if.ovf;
                held_unf = sp_if.unf;
                if (hp_if.out_valid) begin
                    if (hp_q.size() == 0) begin
                        check("hp_unexpected_output", hp_q.size(), 1);
                    end else begin
                        e = hp_q.pop_front();
                        check("hp_result", hp_if.result, e.res);
                        check("hp_flags", {hp_if.ovf, hp_if.unf}, {e.ovf, e.unf});
                        check("hp_latency", cyc - e.acc, 3);
                    end
                end
            end
        end
    endtask

    task automatic send_sp(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] r, input logic o, input logic u, input bit lat);
        bit ok = 1'b0;
        sp_if.a        = a;
        sp_if.b        = b;
        sp_if.sub      = s;
        sp_if.in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (sp_if.in_ready) begin
                ok = 1'b1;
                sp_q.push_back('{res: r, ovf: o, unf: u, acc: cyc, lat: lat});
            end
        end
        if (!ok) check("sp_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        sp_if.in_valid = 1'b0;
    endtask

    task automatic send_hp(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input logic [15:0] r, input logic o, input logic u);
        bit ok = 1'b0;
        hp_if.a        = a;
        hp_if.b        = b;
        hp_if.sub      = s;
        hp_if.in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (hp_if.in_ready) begin
                ok = 1'b1;
                hp_q.push_back('{res: {16'h0, r}, ovf: o, unf: u, acc: cyc, lat: 1'b1});
            end
        end
        if (!ok) check("hp_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        hp_if.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && (sp_q.size() != 0 || hp_q.size() != 0); i++)
            @(posedge clk);
        check(tag, sp_q.size() + hp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        sp_if.in_valid  = 1'b0;
        sp_if.a         = '0;
        sp_if.b         = '0;
        sp_if.sub       = 1'b0;
        sp_if.out_ready = 1'b1;
        hp_if.in_valid  = 1'b0;
        hp_if.a         = '0;
        hp_if.b         = '0;
        hp_if.sub       = 1'b0;
        hp_if.out_ready = 1'b1;

        fork
            monitor();
        join_none

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", sp_if.out_valid, 0);
        check("rst_result", sp_if.result, 0);
        check("rst_flags", {sp_if.ovf, sp_if.unf}, 0);
        check("rst_in_ready", sp_if.in_ready, 0);
        check("rst_hp_out_valid", hp_if.out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", sp_if.in_ready, 1);
        @(posedge clk);
        #1;

        // directed single-precision cases
        send_sp(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b1);
        send_sp(32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b1);
        send_sp(32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 1'b0, 1'b0, 1'b1);
        send_sp(32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1);
        send_sp(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1);
        send_sp(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1);
        send_sp(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1);
        send_sp(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1);
        send_sp(32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 1'b0, 1'b0, 1'b1);
        send_sp(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0, 1'b1);
        wait_drain("directed_drain");

        // back-to-back stream with a 5-cycle consumer stall
        fork
            begin
                send_sp(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0);
                send_sp(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0);
                send_sp(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0, 1'b0, 1'b0);
                send_sp(32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0);
                send_sp(32'h40800000, 32'h40800000, 1'b0, 32'h41000000, 1'b0, 1'b0, 1'b0);
                send_sp(32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 1'b0, 1'b0, 1'b0);
                send_sp(32'h40800000, 32'h3F800000, 1'b0, 32'h40A00000, 1'b0, 1'b0, 1'b0);
                send_sp(32'h40400000, 32'h40400000, 1'b0, 32'h40C00000, 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                sp_if.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready_low", sp_if.in_ready, 0);
                end
                @(posedge clk);
                #1;
                sp_if.out_ready = 1'b1;
            end
        join
        wait_drain("stream_drain");

        // reset with three operations in flight
        send_sp(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b1);
        send_sp(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b1);
        send_sp(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        sp_q.delete();
        @(negedge clk);
        check("midrst_in_ready", sp_if.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", sp_if.out_valid, 0);
        check("midrst_in_ready_after", sp_if.in_ready, 1);
        repeat (8) @(posedge clk);
        #1;
        send_sp(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0, 1'b0, 1'b1);
        wait_drain("post_reset_drain");

        // reduced format EXP_W=5, MAN_W=10
        send_hp(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0);
        send_hp(16'h3C00, 16'h3800, 1'b1, 16'h3800, 1'b0, 1'b0);
        send_hp(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0);
        wait_drain("hp_drain");

        check("final_sp_queue", sp_q.size(), 0);
        check("final_hp_queue", hp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Parametrised, three-stage pipelined IEEE-754-style floating-point adder/subtractor with valid/ready flow control. It generalises the single-precision exponent-difference and sign-aligned mantissa-add datapath to any exponent/mantissa width, adds a runtime subtract mode, normalisation and exception flags, and registers every stage. It sits in the FPA pipeline between the operand source and the writeback or consumer stage.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa (fraction) width; W = 1+EXP_W+MAN_W
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  pipe accepts operands this cycle
- a, b  in  W each  operands {sign, exp, frac}
- sub  in  1  0: a+b, 1: a−b
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  W  sum/difference
- ovf  out  1  exponent overflow, result forced to ±inf
- unf  out  1  exponent underflow, result flushed to ±0

## Operation
- Format: bias = 2^(EXP_W−1)−1. exp==0 is treated as zero; the mantissa is ignored, so denormals are flushed on input. exp all-ones is outside the supported range and gives an undefined result. Rounding is truncation toward zero.
- Stage 1 (align):
  - b's effective sign is sb^sub; effsub = sa^sb^sub.
  - Prepend the hidden 1 to nonzero operands.
  - Swap so the "big" operand has the larger {exp, mant}.
  - dif = e_big − e_small, EXP_W bits, never negative after the swap.
  - Right-shift the small mantissa by dif into a MAN_W+3-bit field (hidden + frac + 2 guard bits). If dif ≥ MAN_W+3 the shifted mantissa is 0.
- Stage 2 (add):
  - sum = m_big + m_small, or m_big − m_small when effsub. The field is MAN_W+4 bits including carry.
  - Subtraction uses the two's complement of m_small and is never negative.
  - Result sign = big sign. Carry, exponent and sign are registered.
- Stage 3 (normalise):
  - sum==0 → +0, no flags.
  - If carry is set, shift right 1 and exp+1.
  - Otherwise shift left by the leading-zero count lz and set exp−lz.
  - Drop the hidden and guard bits.
  - Computed exp ≥ 2^EXP_W−1 → {sign, all-ones, 0}, ovf=1.
  - Computed exp ≤ 0 → {sign, 0, 0}, unf=1.
  - The exponent arithmetic is EXP_W+2 bits signed, so there is no wrap.
- Flow control: one global enable, en = !(out_valid && !out_ready).
  - in_ready = en && !rst.
  - All stage registers and their valid bits advance only when en is high.
  - Bubbles advance as invalid.
  - No operand is ever dropped or duplicated.

## Timing
- Latency is 3 cycles from accepted input (in_valid && in_ready) to out_valid when out_ready is held high. Throughput is 1 result/cycle.
- While stalled (en=0), all three stages hold and result, ovf and unf stay stable.
- A simultaneous accept and output in the same cycle is legal and keeps the pipe full.
- Reset: stage valids, out_valid, result, ovf and unf all go to 0 on the cycle rst is sampled high. A reset mid-operation discards in-flight data. in_ready is 0 while rst is high and 1 in the first cycle after reset.
- ovf and unf are valid only with out_valid and travel with their result.

## Structure
- Package fp_pkg holds:
  - default EXP_W/MAN_W and the bias function
  - typedefs s1_t (sign, effsub, exp, m_big, m_small, valid) and s2_t (sign, exp, sum, valid)
  - the MAN_W+3 guard-width constant
- Sub-module fp_lzc (parametrised leading-zero counter on MAN_W+3 bits, combinational) is used in stage 3. Everything else stays in fp_addsub_pipe.

## Test plan
- 0x3F800000 + 0x3F800000, sub=0 → 0x40000000 after 3 cycles, flags 0.
- 0x40400000 + 0xBF800000 → 0x40000000. Also 0x3F800000 − 0x3F000000 (sub=1) → 0x3F000000. Also 0x3FC00000 − 0x3FC00000 → 0x00000000.
- Alignment: 0x3F800000 + 0x30800000 (dif=30 ≥ 26) → 0x3F800000. 0x3F800000 + 0x33800000 → 0x3F800000, truncated.
- Overflow/underflow:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with ovf=1.
  - 0x00800001 − 0x00800000 → 0x00000000 with unf=1.
- Backpressure: stream 8 back-to-back operands with out_ready low for 5 cycles mid-stream. in_ready drops while the pipe is full; all 8 results emerge in order with no loss or duplication and stay stable while stalled.
- Reset mid-stream with 3 operations in flight → out_valid=0 next cycle, and no stale result appears afterward. Repeat at EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 → 0x4000.
